// File: rtl/div_unit_if.sv
// Handshake and data bundle for the 32-bit divider: request side driven by the
// master, status and results driven by the divider.
interface div_unit_if;
  logic        start;
  logic        sgn;
  logic [31:0] sr;
  logic [31:0] tg;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] lo;
  logic [31:0] hi;

  modport master (output start, sgn, sr, tg, input busy, done, dz, lo, hi);
  modport slave  (input start, sgn, sr, tg, output busy, done, dz, lo, hi);
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU): one quotient bit per cycle,
// a final sign-fix cycle, and a fixed 33-cycle latency (1 cycle on divide-by-zero).
module div_unit (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic        neg_quo;
  logic        neg_rem;
  logic        dz_pend;
  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic        dz_q;
  logic        done_q;

  logic [31:0] sr_mag;
  logic [31:0] tg_mag;
  logic [32:0] shifted;
  logic [32:0] diff;

  assign sr_mag  = (bus.sgn && bus.sr[31]) ? (~bus.sr + 32'd1) : bus.sr;
  assign tg_mag  = (bus.sgn && bus.tg[31]) ? (~bus.tg + 32'd1) : bus.tg;
  assign shifted = {rem, quo[31]};
  // Bit 32 of the 33-bit difference is the borrow: set means the divisor did not fit.
  assign diff    = shifted - {1'b0, dvs};

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.lo   = lo_q;
  assign bus.hi   = hi_q;

  // NOTE: every register here is a flop with an async clear and is written with
  // non-blocking assignments; there is no memory array, so nothing is left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      dz_pend <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_quo <= bus.sgn & (bus.sr[31] ^ bus.tg[31]);
            neg_rem <= bus.sgn & bus.sr[31];
            rem     <= '0;
            dvs     <= tg_mag;
            cnt     <= 5'd31;
            if (bus.tg == 32'd0) begin
              // Divide-by-zero keeps the raw dividend so it can be returned in hi.
              dz_pend <= 1'b1;
              quo     <= bus.sr;
              state   <= FIX;
            end else begin
              dz_pend <= 1'b0;
              quo     <= sr_mag;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (!diff[32]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          done_q <= 1'b1;
          state  <= IDLE;
          if (dz_pend) begin
            lo_q <= 32'hFFFF_FFFF;
            hi_q <= quo;
            dz_q <= 1'b1;
          end else begin
            lo_q <= neg_quo ? (~quo + 32'd1) : quo;
            hi_q <= neg_rem ? (~rem + 32'd1) : rem;
            dz_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a reference model fills a scoreboard queue at each
// accepted start and entries are popped and compared when done pulses.
module tb_div_unit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb[$];
  logic [31:0] prev_lo = '0;
  logic [31:0] prev_hi = '0;

  div_unit_if bus ();

  div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    r.dz  = 1'b0;
    r.lat = 33;
    if (b == 32'd0) begin
      r.lo  = 32'hFFFF_FFFF;
      r.hi  = a;
      r.dz  = 1'b1;
      r.lat = 1;
    end else if (!s) begin
      r.lo = a / b;
      r.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.lo = 32'h8000_0000;
      r.hi = 32'd0;
    end else begin
      r.lo = $signed(a) / $signed(b);
      r.hi = $signed(a) % $signed(b);
    end
    return r;
  endfunction

  // Drive one request through its accepting edge, then scramble the operands.
  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.sr    = a;
    bus.tg    = b;
    sb.push_back(model(s, a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.sgn   = ~s;
    bus.sr    = $urandom;
    bus.tg    = $urandom;
    check("accepted_busy", {31'd0, bus.busy}, 32'd1);
  endtask

  // Wait (bounded) for done; optionally pulse a stray start at CALC cycle inject_at.
  task automatic wait_done(input int inject_at);
    res_t e;
    int   cyc;
    bit   seen;
    seen = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (cyc == 16) begin
        check("hold_lo", bus.lo, prev_lo);
        check("hold_hi", bus.hi, prev_hi);
      end
      if (cyc == inject_at) begin
        check("busy_at_inject", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b1;
        bus.sgn   = 1'b0;
        bus.sr    = 32'd999;
        bus.tg    = 32'd3;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("latency", cyc, e.lat);
      check("lo", bus.lo, e.lo);
      check("hi", bus.hi, e.hi);
      check("dz", {31'd0, bus.dz}, {31'd0, e.dz});
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      prev_lo = e.lo;
      prev_hi = e.hi;
    end
  endtask

  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    start_op(s, a, b);
    wait_done(0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.sr    = '0;
    bus.tg    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dz", {31'd0, bus.dz}, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'd5, 32'hFFFF_FFFF);
    run_op(1'b0, 32'h0000_1234, 32'd0);
    run_op(1'b1, 32'h8000_0000, 32'd0);

    // Stray start mid-CALC is ignored; then a back-to-back start in the done cycle.
    start_op(1'b0, 32'd1000, 32'd13);
    wait_done(10);
    start_op(1'b1, 32'hFFFF_FF00, 32'd17);
    wait_done(0);

    for (int i = 0; i < 4; i++) begin
      run_op(i[0], $urandom, $urandom_range(1, 32'h0000_FFFF) ^ {i[1], 31'd0});
    end

    // Reset at CALC cycle 15 aborts with no done pulse.
    start_op(1'b0, 32'd100, 32'd7);
    void'(sb.pop_back());
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_dz", {31'd0, bus.dz}, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    prev_lo = '0;
    prev_hi = '0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) check("abort_no_done", {31'd0, bus.done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    run_op(1'b0, 32'd100, 32'd7);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 start  input  1  request a division; sampled on a rising edge of clk.
REQ-006 sgn  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-007 sr  input  32  dividend (rs).
REQ-008 tg  input  32  divisor (rt).
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  single-cycle pulse; high when hi/lo are updated.
REQ-011 dz  output  1  divide-by-zero flag for the last completed operation.
REQ-012 lo  output  32  quotient.
REQ-013 hi  output  32  remainder.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIX; busy SHALL be 1 exactly when the state is not IDLE.
REQ-015 In IDLE with start=1 at edge E0, the block SHALL latch sr, tg and sgn; later input changes SHALL have no effect until done.
REQ-016 start while busy=1 SHALL be ignored; start in the cycle done=1 SHALL be accepted, because busy=0 in that cycle.
REQ-017 At E0 with tg!=0, the block SHALL load the dividend magnitude (two's-complement absolute value when sgn=1) and the divisor magnitude, clear the partial remainder, set the iteration counter to 31, and enter CALC.
REQ-018 At each CALC edge, the block SHALL left-shift {remainder, dividend}.
REQ-019 At each CALC edge, the block SHALL form a 33-bit difference: shifted remainder minus divisor magnitude.
REQ-020 If that difference has no borrow, the block SHALL keep the difference and shift in quotient bit 1; otherwise it SHALL restore the remainder and shift in 0.
REQ-021 There SHALL be exactly 32 CALC edges (E1..E32); after E32 the state SHALL be FIX.
REQ-022 At E33 (FIX), when sgn=1, the block SHALL negate the quotient if the operand signs differ and negate the remainder if the dividend was negative.
REQ-023 At E33, the block SHALL write lo/hi, pulse done=1 for one cycle, set dz=0, and return to IDLE.
REQ-024 Latency from the accepting edge to done SHALL be 33 cycles, independent of operand values.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0, with no flag raised.
REQ-026 Divide-by-zero (tg=0 at E0) SHALL skip CALC: at E1 lo=0xFFFFFFFF, hi=latched sr, dz=1, done=1, state IDLE.
REQ-027 hi, lo and dz SHALL hold their values from done until the next completion; they SHALL NOT change during CALC.
REQ-028 Unsigned results SHALL satisfy sr = lo*tg + hi and hi < tg.
REQ-029 Signed results SHALL satisfy |hi| < |tg|, with hi zero or carrying the sign of sr.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with busy=0, done=0, dz=0, lo=0, hi=0, and all internal registers and counter cleared.
REQ-031 Reset asserted mid-CALC SHALL abort immediately with no done pulse; the first start after rst_n rises SHALL behave normally.

Verification
REQ-032 The bench SHALL cover unsigned sr=100, tg=7 -> done exactly 33 cycles after the start edge, lo=14, hi=2, dz=0.
REQ-033 The bench SHALL cover signed sr=0xFFFFFFF9 (-7), tg=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and sr=7, tg=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
REQ-034 The bench SHALL cover extremes: unsigned 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0; signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; unsigned 5/0xFFFFFFFF -> lo=0, hi=5.
REQ-035 The bench SHALL cover divide-by-zero sr=0x1234, tg=0 -> done 1 cycle after start, dz=1, lo=0xFFFFFFFF, hi=0x1234.
REQ-036 The bench SHALL cover start pulsed at CALC cycle 10 with different operands -> ignored; the original result is delivered at cycle 33. It SHALL also cover back-to-back start in the done cycle -> accepted.
REQ-037 The bench SHALL cover rst_n=0 at CALC cycle 15 -> all outputs 0 immediately, no done pulse; a following 100/7 completes correctly.
